// File: rtl/serial_tx_ctrl.sv
// serial_tx_ctrl: memory-mapped 8N1 UART transmitter with a byte FIFO and a pollable status word
module serial_tx_ctrl #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD = 115200,
  parameter int DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        tx,
  output logic        busy
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NW = $clog2(DIV);
  localparam logic [NW-1:0] LAST = NW'(DIV - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q;
  logic [NW-1:0] cnt_q;
  logic [2:0] idx_q;
  logic [7:0] shift_q;
  logic tx_q, ov_q, ov_d;
  logic [31:0] dout_q, status;
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic empty, full, wrap, pop, push_req, push, drop, clr;
  logic unused;
  assign unused = ^{addr[31:3], addr[1:0], din[31:8]};
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
  assign wrap = cnt_q == LAST;
  // A pop happens when the line is free: from IDLE, or as a STOP bit completes
  assign pop = !empty && (state_q == IDLE || (state_q == STOP && wrap));
  assign push_req = sel && we && !addr[2];
  // A full FIFO still accepts a byte when the head leaves on the same edge
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;
  assign clr = sel && we && addr[2] && din[0];
  assign count_d = count_q + CW'(push) - CW'(pop);
  assign ov_d = drop ? 1'b1 : clr ? 1'b0 : ov_q;
  assign busy = state_q != IDLE || !empty;
  assign status = {{(28 - CW){1'b0}}, count_q, ov_q, empty, full, busy};
  assign tx = tx_q;
  assign dout = dout_q;
  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= din[7:0];
  end
  // FIFO pointers, occupancy, sticky overflow and the registered bus read port
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      ov_q <= 1'b0;
      dout_q <= '0;
    end else begin
      wptr_q <= push ? wptr_q + 1'b1 : wptr_q;
      rptr_q <= pop ? rptr_q + 1'b1 : rptr_q;
      count_q <= count_d;
      ov_q <= ov_d;
      dout_q <= (sel && re) ? (addr[2] ? status : '0) : dout_q;
    end
  end
  // Frame sequencer: start bit, eight data bits LSB first, stop bit, each DIV cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
    end else begin
      cnt_q <= (state_q == IDLE || wrap) ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: if (pop) begin
          shift_q <= mem_q[rptr_q];
          state_q <= START;
          tx_q <= 1'b0;
        end
        START: if (wrap) begin
          state_q <= DATA;
          idx_q <= '0;
          tx_q <= shift_q[0];
        end
        DATA: if (wrap) begin
          if (idx_q == 3'd7) begin
            state_q <= STOP;
            tx_q <= 1'b1;
          end else begin
            shift_q <= shift_q >> 1;
            idx_q <= idx_q + 1'b1;
            tx_q <= shift_q[1];
          end
        end
        default: if (wrap) begin
          state_q <= pop ? START : IDLE;
          shift_q <= pop ? mem_q[rptr_q] : shift_q;
          tx_q <= !pop;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_tx_ctrl.sv
// tb_serial_tx_ctrl: randomized and directed checks of serial_tx_ctrl against a frame-timeline model
module tb_serial_tx_ctrl;
  localparam int CLK_HZ = 1000;
  localparam int BAUD = 100;
  localparam int DEPTH = 16;
  localparam int DIV = CLK_HZ / BAUD;
  localparam int FRAME = 10 * DIV;
  logic clock = 1'b0, reset, sel, we, re, tx, busy;
  logic [31:0] addr, din, dout;
  int n_cmp = 0, n_err = 0;
  logic [7:0] mq[$];
  logic [7:0] m_cur;
  int m_pos;
  logic m_ov;
  logic [31:0] m_dout;
  serial_tx_ctrl #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .sel(sel), .we(we), .re(re),
    .addr(addr), .din(din), .dout(dout), .tx(tx), .busy(busy)
  );
  always #5 clock = ~clock;
  function automatic logic m_tx();
    int b;
    if (m_pos < 0) return 1'b1;
    b = m_pos / DIV;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction
  function automatic logic m_busy();
    return m_pos >= 0 || mq.size() > 0;
  endfunction
  function automatic logic [31:0] m_status();
    int c;
    c = mq.size();
    return (32'(c) << 4) | (m_ov ? 32'h8 : 0) | (c == 0 ? 32'h4 : 0) | (c == DEPTH ? 32'h2 : 0) | (m_busy() ? 32'h1 : 0);
  endfunction
  task automatic cyc(input logic r, input logic s, input logic w, input logic rd, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] st;
    logic fend, pop, wr, drop;
    reset = r; sel = s; we = w; re = rd; addr = a; din = d;
    @(posedge clock);
    if (r) begin
      mq.delete(); m_pos = -1; m_ov = 1'b0; m_dout = '0;
    end else begin
      st = m_status();
      fend = m_pos == FRAME - 1;
      pop = mq.size() > 0 && (m_pos < 0 || fend);
      wr = s && w && !a[2];
      drop = wr && mq.size() == DEPTH && !pop;
      if (s && rd) m_dout = a[2] ? st : 32'h0;
      if (pop) begin m_cur = mq.pop_front(); m_pos = 0; end
      else if (m_pos >= 0) m_pos = fend ? -1 : m_pos + 1;
      if (wr && !drop) mq.push_back(d[7:0]);
      if (drop) m_ov = 1'b1;
      else if (s && w && a[2] && d[0]) m_ov = 1'b0;
    end
    #1;
  endtask
  task automatic idle(); cyc(0, 0, 0, 0, 0, 0); endtask
  task automatic wr_data(input logic [7:0] b); cyc(0, 1, 1, 0, 32'h0, {24'h0, b}); endtask
  task automatic rd_status(); cyc(0, 1, 0, 1, 32'h4, 0); endtask
  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0 || dout !== 32'h0) begin
      n_err++; $display("FAIL reset_state tx=%b busy=%b dout=%h want 1 0 0", tx, busy, dout);
    end
    rd_status();
    n_cmp++;
    if (dout !== 32'h4) begin n_err++; $display("FAIL reset_status got %h want 00000004", dout); end
  endtask
  task automatic test_single_frame();
    wr_data(8'h55);
    for (int i = 1; i <= 105; i++) begin
      idle();
      n_cmp++;
      if (tx !== m_tx() || busy !== m_busy()) begin
        n_err++; $display("FAIL single_frame cyc %0d tx=%b busy=%b want %b %b", i, tx, busy, m_tx(), m_busy());
      end
    end
    n_cmp++;
    if (busy !== 1'b0 || tx !== 1'b1) begin n_err++; $display("FAIL single_frame_end busy=%b tx=%b want 0 1", busy, tx); end
  endtask
  task automatic test_back_to_back();
    int low_run, last_low;
    wr_data(8'hA5);
    wr_data(8'h3C);
    last_low = 0; low_run = 0;
    for (int i = 2; i <= 205; i++) begin
      idle();
      n_cmp++;
      if (tx !== m_tx() || busy !== m_busy()) begin
        n_err++; $display("FAIL back_to_back cyc %0d tx=%b busy=%b want %b %b", i, tx, busy, m_tx(), m_busy());
      end
      if (i == 101) begin
        n_cmp++;
        if (tx !== 1'b0) begin n_err++; $display("FAIL b2b_gap cyc 101 tx=%b want 0", tx); end
      end
      if (i == 201) begin
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_total busy=%b want 0", busy); end
      end
    end
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 18; i++) wr_data(8'($urandom));
    rd_status();
    n_cmp++;
    if (dout !== 32'h10B || dout !== m_status() | 32'h0 && 0) begin
      n_err++; $display("FAIL overflow_status got %h want 0000010b", dout);
    end
    cyc(0, 1, 1, 0, 32'h4, 32'h1);
    rd_status();
    n_cmp++;
    if (dout !== 32'h103) begin n_err++; $display("FAIL overflow_clear got %h want 00000103", dout); end
  endtask
  task automatic test_reset_midframe();
    cyc(1, 0, 0, 0, 0, 0);
    wr_data(8'hFF);
    for (int i = 0; i < 3; i++) wr_data(8'($urandom));
    for (int g = 0; g < 100 && m_pos != 44; g++) idle();
    cyc(1, 0, 0, 0, 0, 0);
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL midframe_reset tx=%b busy=%b want 1 0", tx, busy); end
    rd_status();
    n_cmp++;
    if (dout !== 32'h4) begin n_err++; $display("FAIL midframe_status got %h want 00000004", dout); end
    for (int i = 0; i < 300; i++) begin
      idle();
      n_cmp++;
      if (tx !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL midframe_quiet cyc %0d tx=%b busy=%b want 1 0", i, tx, busy); end
    end
  endtask
  task automatic test_full_pop();
    int g;
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) wr_data(8'($urandom));
    g = 0;
    while (m_pos != FRAME - 1 && g < 2 * FRAME) begin idle(); g++; end
    n_cmp++;
    if (g >= 2 * FRAME) begin n_err++; $display("FAIL full_pop_timeout pos=%0d want %0d", m_pos, FRAME - 1); end
    wr_data(8'h77);
    n_cmp++;
    if (tx !== m_tx() || tx !== 1'b0) begin n_err++; $display("FAIL full_pop_start tx=%b want 0", tx); end
    rd_status();
    n_cmp++;
    if (dout[8:4] !== 5'd16 || dout[3] !== 1'b0 || dout !== m_status()) begin
      n_err++; $display("FAIL full_pop_status got %h want count 16 overflow 0 (%h)", dout, m_status());
    end
  endtask
  task automatic test_read();
    logic [31:0] held;
    rd_status();
    held = dout;
    cyc(0, 0, 0, 1, 32'h4, 0);
    n_cmp++;
    if (dout !== held) begin n_err++; $display("FAIL read_nosel got %h want %h", dout, held); end
    cyc(0, 1, 0, 1, 32'h0, 0);
    n_cmp++;
    if (dout !== 32'h0) begin n_err++; $display("FAIL read_data got %h want 00000000", dout); end
  endtask
  task automatic test_random();
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      cyc(0, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0,
          $urandom, $urandom_range(0, 3) == 0 ? 32'h1 : $urandom);
      n_cmp++;
      if (tx !== m_tx() || busy !== m_busy() || dout !== m_dout) begin
        n_err++; $display("FAIL random cyc %0d tx=%b busy=%b dout=%h want %b %b %h", i, tx, busy, dout, m_tx(), m_busy(), m_dout);
      end
    end
  endtask
  initial begin
    m_pos = -1; m_ov = 1'b0; m_dout = '0; m_cur = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_full_pop();
    test_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/serial_tx_ctrl.md
Name: serial_tx_ctrl

Overview:
- Memory-mapped UART transmit controller for the CPU's serial peripheral slot.
- Decoded by the MMU select line; sits on the data-memory bus next to the LED, segment and timer peripherals.
- Buffers CPU byte writes in a FIFO and sequences them out on a single 8N1 TX line at a fixed baud rate.
- Exposes a status word so software can poll instead of dropping bytes.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- BAUD, 115200, line rate. DIV = CLK_HZ/BAUD, integer-truncated; DIV must be >= 2.
- DEPTH, 16, FIFO entries; must be a power of 2. CW = log2(DEPTH)+1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sel  in  1  MMU select for this peripheral.
- we  in  1  bus write strobe; qualified by sel.
- re  in  1  bus read strobe; qualified by sel.
- addr  in  32  byte address; only addr[2] is decoded (0 = DATA, 1 = STATUS).
- din  in  32  write data.
- dout  out  32  registered read data.
- tx  out  1  UART line, idle high.
- busy  out  1  high when a frame is in flight or the FIFO is non-empty.

Behaviour:
- Clock port is named clock and reset port is named reset; one clock; reset is synchronous and active-high.
- Reset values: tx=1, dout=0, busy=0, FIFO empty (count=0), overflow=0, FSM=IDLE, baud counter=0, bit index=0.
- A reset asserted mid-frame aborts the frame. tx is 1 after that edge; no partial stop bit is sent.
- DATA write (sel&we&addr[2]==0): pushes din[7:0] at the edge.
  - If full and no pop occurs in the same cycle: byte dropped, overflow set (sticky).
  - If full and a pop occurs in the same cycle: push accepted, count unchanged.
- STATUS write (sel&we&addr[2]==1): din[0]=1 clears overflow. If a drop occurs in the same cycle, set wins.
- Read (sel&re): at the edge, dout <= the selected word.
  - DATA reads return 0.
  - STATUS = {zeros, count[CW-1:0] at [4+:CW], overflow[3], empty[2], full[1], busy[0]}.
  - Read data is valid one cycle after the strobe. dout holds its value when there is no read.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty: pop the head into the shift register, clear the baud counter, go to START.
  - START: tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first, each bit held DIV cycles. After a bit: shift right, increment index. After bit 7, go to STOP.
  - STOP: tx=1 for DIV cycles. At the end: if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap); else go to IDLE.
- Baud counter counts 0..DIV-1 and wraps at DIV-1, when the state/bit advances. One frame = exactly 10*DIV cycles.
- Latency: with an idle FSM and empty FIFO, a write at edge E0 causes the pop at E1, so tx is low after E1 (one-cycle latency).
- FIFO: circular read/write pointers with an explicit count.
  - Pointers wrap modulo DEPTH.
  - full = (count==DEPTH), empty = (count==0).
  - A simultaneous push and pop when empty is not allowed: the pop requires non-empty before the edge, so only the push takes effect.
- busy = (state!=IDLE) | !empty, registered-equivalent timing (derived from registered state).
- Writes without sel, or with sel but no we, have no effect. Reads without sel leave dout unchanged.

Test Plan:
- CLK_HZ=1000, BAUD=100 (DIV=10); reset, then write 0x55 to DATA -> tx low for cycles 1-10, bits 1,0,1,0,1,0,1,0 each for 10 cycles, high from cycle 91, busy=0 after cycle 101.
- Write 0xA5, 0x3C in consecutive cycles -> two back-to-back frames totalling 200 cycles, no extra idle cycle between the STOP of frame 1 and the START of frame 2.
- DEPTH=16: write 18 bytes in 18 consecutive cycles, starting idle -> first byte popped, 16 buffered, 1 dropped; STATUS read = count 16, overflow=1, full=1, empty=0, busy=1 (0x10B); then write 1 to STATUS -> overflow=0.
- Assert reset at cycle 45 of a 0xFF frame with 3 bytes queued -> tx=1 next cycle, STATUS reads 0x4 (empty only), no further frames.
- Write to the full FIFO in the same cycle STOP ends and pops -> push accepted, count stays 16, overflow stays 0.
- Read STATUS with sel=0 -> dout unchanged; read DATA -> dout=0 one cycle later.
